// File: rtl/sum_tx_sequencer.sv
// Frames the 5-bit adder result as two ASCII decimal digits (optionally followed by CR LF)
// and hands the bytes to uart_tx one at a time, started by a send button or an auto-send timer.
module sum_tx_sequencer #(
    parameter int APPEND_CRLF = 1,
    parameter int AUTO_PERIOD = 50000000,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       send_n,
    input  logic       auto_en,
    input  logic [4:0] sum_in,
    input  logic       uart_tx_busy,
    output logic       uart_tx_en,
    output logic [7:0] uart_tx_data,
    output logic       seq_busy,
    output logic       frame_done,
    output logic       tx_error
);
    localparam int AUTO_W = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
    localparam int ACK_W  = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);
    // Error is registered, so the abort decision is taken one count early to land
    // the tx_error pulse exactly ACK_TIMEOUT cycles after the strobe.
    localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 2);
    localparam logic [1:0]        LAST_IDX  = (APPEND_CRLF != 0) ? 2'd3 : 2'd1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STROBE, S_ACK, S_DONE} state_t;

    state_t             state_q;
    logic               send_meta_q, send_sync_q, send_prev_q;
    logic [AUTO_W-1:0]  auto_cnt_q, auto_cnt_d;
    logic               auto_tick, send_fall, request;
    logic [ACK_W-1:0]   ack_cnt_q;
    logic [1:0]         idx_q;
    logic [4:0]         sum_q;
    logic               pending_q;
    logic [7:0]         data_q;
    logic               seq_busy_q, frame_done_q, tx_error_q;
    logic [1:0]         tens;
    logic [4:0]         ones;
    logic [7:0]         byte_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            send_meta_q <= 1'b1;
            send_sync_q <= 1'b1;
            send_prev_q <= 1'b1;
            auto_cnt_q  <= '0;
        end else begin
            send_meta_q <= send_n;
            send_sync_q <= send_meta_q;
            send_prev_q <= send_sync_q;
            auto_cnt_q  <= auto_cnt_d;
        end
    end

    always_comb begin
        auto_tick  = 1'b0;
        auto_cnt_d = auto_cnt_q + AUTO_W'(1);
        if (!auto_en) begin
            auto_cnt_d = '0;
        end else if (auto_cnt_q == AUTO_LAST) begin
            auto_cnt_d = '0;
            auto_tick  = 1'b1;
        end
    end

    assign send_fall = send_prev_q & ~send_sync_q;
    assign request   = send_fall | auto_tick;

    always_comb begin
        if (sum_q >= 5'd30)      tens = 2'd3;
        else if (sum_q >= 5'd20) tens = 2'd2;
        else if (sum_q >= 5'd10) tens = 2'd1;
        else                     tens = 2'd0;
        ones = sum_q - 5'(tens) * 5'd10;
        case (idx_q)
            2'd0:    byte_sel = 8'h30 + {6'b0, tens};
            2'd1:    byte_sel = 8'h30 + {3'b0, ones};
            2'd2:    byte_sel = 8'h0D;
            default: byte_sel = 8'h0A;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ack_cnt_q    <= '0;
            idx_q        <= '0;
            sum_q        <= '0;
            pending_q    <= 1'b0;
            data_q       <= '0;
            seq_busy_q   <= 1'b0;
            frame_done_q <= 1'b0;
            tx_error_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            tx_error_q   <= 1'b0;
            if (request && state_q != S_IDLE)
                pending_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (request || pending_q) begin
                        sum_q      <= sum_in;
                        idx_q      <= '0;
                        pending_q  <= 1'b0;
                        seq_busy_q <= 1'b1;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    data_q  <= byte_sel;
                    state_q <= S_STROBE;
                end
                S_STROBE: begin
                    if (!uart_tx_busy) begin
                        ack_cnt_q <= '0;
                        state_q   <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (uart_tx_busy) begin
                        state_q <= S_DONE;
                    end else if (ack_cnt_q == ACK_LAST) begin
                        tx_error_q <= 1'b1;
                        pending_q  <= 1'b0;
                        seq_busy_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + ACK_W'(1);
                    end
                end
                S_DONE: begin
                    if (!uart_tx_busy) begin
                        if (idx_q == LAST_IDX) begin
                            frame_done_q <= 1'b1;
                            seq_busy_q   <= 1'b0;
                            state_q      <= S_IDLE;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= S_LOAD;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The strobe must coincide with the STROBE cycle that sees busy low, so it is decoded, not registered.
    assign uart_tx_en   = (state_q == S_STROBE) && !uart_tx_busy;
    assign uart_tx_data = data_q;
    assign seq_busy     = seq_busy_q;
    assign frame_done   = frame_done_q;
    assign tx_error     = tx_error_q;
endmodule

// File: tb/tb_sum_tx_sequencer.sv
// Directed bench for sum_tx_sequencer with a behavioural uart_tx model that can be made unresponsive.
module tb_sum_tx_sequencer;
    localparam int ACK_TO   = 40;
    localparam int PERIOD   = 64;
    localparam int BUSY_LEN = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       send_n = 1'b1;
    logic       auto_en = 1'b0;
    logic [4:0] sum_in = 5'd0;
    logic       uart_tx_busy;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       seq_busy;
    logic       frame_done;
    logic       tx_error;

    always #5 clk = ~clk;

    sum_tx_sequencer #(
        .APPEND_CRLF(1),
        .AUTO_PERIOD(PERIOD),
        .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .send_n(send_n),
        .auto_en(auto_en),
        .sum_in(sum_in),
        .uart_tx_busy(uart_tx_busy),
        .uart_tx_en(uart_tx_en),
        .uart_tx_data(uart_tx_data),
        .seq_busy(seq_busy),
        .frame_done(frame_done),
        .tx_error(tx_error)
    );

    // UART model and event monitor
    int         busy_cnt = 0;
    bit         uart_alive = 1'b1;
    int         cyc = 0;
    logic [7:0] bytes_q[$];
    int         strobe_cyc[$];
    int         done_cnt = 0, err_cnt = 0;
    int         done_cyc = -1, err_cyc = -1, rise_cyc = -1;
    logic       busy_prev = 1'b0;

    assign uart_tx_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        if (uart_tx_en) begin
            bytes_q.push_back(uart_tx_data);
            strobe_cyc.push_back(cyc);
            if (uart_alive) busy_cnt <= BUSY_LEN;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (frame_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (tx_error) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (seq_busy && !busy_prev) rise_cyc <= cyc;
        busy_prev <= seq_busy;
        cyc <= cyc + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_send(input int low, input int high);
        @(negedge clk);
        send_n = 1'b0;
        repeat (low) @(negedge clk);
        send_n = 1'b1;
        repeat (high) @(negedge clk);
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " frame_done reached"}, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic send_and_check(input logic [4:0] val, input logic [7:0] e0, input logic [7:0] e1,
                                  input string tag);
        int b = bytes_q.size();
        int d = done_cnt;
        sum_in = val;
        pulse_send(5, 2);
        wait_done(d + 1, 200, tag);
        repeat (20) @(negedge clk);
        check({tag, " byte count"}, 32'(bytes_q.size() - b), 32'd4);
        check({tag, " frame_done count"}, 32'(done_cnt - d), 32'd1);
        if (bytes_q.size() >= b + 4) begin
            check({tag, " byte0"}, 32'(bytes_q[b]),     32'(e0));
            check({tag, " byte1"}, 32'(bytes_q[b + 1]), 32'(e1));
            check({tag, " byte2"}, 32'(bytes_q[b + 2]), 32'h0D);
            check({tag, " byte3"}, 32'(bytes_q[b + 3]), 32'h0A);
            $display("frame %s: sum=%0d bytes %02h %02h %02h %02h", tag, val,
                     bytes_q[b], bytes_q[b + 1], bytes_q[b + 2], bytes_q[b + 3]);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, d, e, fd, a, n;

        // reset state
        repeat (3) @(negedge clk);
        check("rst uart_tx_en",   32'(uart_tx_en),   32'd0);
        check("rst uart_tx_data", 32'(uart_tx_data), 32'd0);
        check("rst seq_busy",     32'(seq_busy),     32'd0);
        check("rst frame_done",   32'(frame_done),   32'd0);
        check("rst tx_error",     32'(tx_error),     32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post-rst seq_busy", 32'(seq_busy), 32'd0);

        // digit encoding, including tens boundaries
        send_and_check(5'd23, 8'h32, 8'h33, "sum23");
        send_and_check(5'd0,  8'h30, 8'h30, "sum0");
        send_and_check(5'd31, 8'h33, 8'h31, "sum31");
        send_and_check(5'd9,  8'h30, 8'h39, "sum9");
        send_and_check(5'd10, 8'h31, 8'h30, "sum10");

        // three presses during a frame coalesce into one extra frame
        b = bytes_q.size();
        d = done_cnt;
        sum_in = 5'd5;
        pulse_send(3, 0);
        n = 0;
        while (!seq_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("coalesce frame started", 32'(seq_busy), 32'd1);
        repeat (3) pulse_send(3, 3);
        wait_done(d + 1, 200, "coalesce first");
        fd = done_cyc;
        wait_done(d + 2, 200, "coalesce second");
        repeat (40) @(negedge clk);
        check("coalesce frame count", 32'(done_cnt - d), 32'd2);
        check("coalesce byte count", 32'(bytes_q.size() - b), 32'd8);
        check("coalesce restart cycle", 32'(rise_cyc), 32'(fd + 1));
        if (bytes_q.size() >= b + 8) begin
            check("coalesce 2nd byte0", 32'(bytes_q[b + 4]), 32'h30);
            check("coalesce 2nd byte1", 32'(bytes_q[b + 5]), 32'h35);
        end
        $display("coalesce: frames=%0d first_done=%0d restart=%0d", done_cnt - d, fd, rise_cyc);

        // value captured at frame start survives a mid-frame change
        b = bytes_q.size();
        d = done_cnt;
        sum_in = 5'd12;
        pulse_send(5, 0);
        n = 0;
        while (bytes_q.size() == b && n < 50) begin
            @(negedge clk);
            n++;
        end
        sum_in = 5'd27;
        wait_done(d + 1, 200, "capture");
        repeat (10) @(negedge clk);
        if (bytes_q.size() >= b + 2) begin
            check("capture byte0", 32'(bytes_q[b]),     32'h31);
            check("capture byte1", 32'(bytes_q[b + 1]), 32'h32);
            $display("capture: bytes %02h %02h", bytes_q[b], bytes_q[b + 1]);
        end else begin
            check("capture byte count", 32'(bytes_q.size() - b), 32'd4);
        end

        // periodic auto-send
        b = strobe_cyc.size();
        d = done_cnt;
        @(negedge clk);
        auto_en = 1'b1;
        a = cyc;
        wait_done(d + 3, 400, "auto");
        auto_en = 1'b0;
        repeat (80) @(negedge clk);
        check("auto frame count", 32'(done_cnt - d), 32'd3);
        check("auto strobe count", 32'(strobe_cyc.size() - b), 32'd12);
        if (strobe_cyc.size() >= b + 12) begin
            check("auto first strobe", 32'(strobe_cyc[b]), 32'(a + PERIOD + 1));
            check("auto period 1", 32'(strobe_cyc[b + 4] - strobe_cyc[b]), 32'(PERIOD));
            check("auto period 2", 32'(strobe_cyc[b + 8] - strobe_cyc[b + 4]), 32'(PERIOD));
            $display("auto: frame strobes at %0d %0d %0d", strobe_cyc[b], strobe_cyc[b + 4], strobe_cyc[b + 8]);
        end

        // UART never acknowledges
        uart_alive = 1'b0;
        b = strobe_cyc.size();
        d = done_cnt;
        e = err_cnt;
        sum_in = 5'd7;
        pulse_send(5, 0);
        n = 0;
        while (err_cnt == e && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("timeout error count", 32'(err_cnt - e), 32'd1);
        check("timeout strobe count", 32'(strobe_cyc.size() - b), 32'd1);
        check("timeout frame_done count", 32'(done_cnt - d), 32'd0);
        check("timeout seq_busy", 32'(seq_busy), 32'd0);
        if (strobe_cyc.size() > b) begin
            check("timeout latency", 32'(err_cyc - strobe_cyc[b]), 32'(ACK_TO));
            $display("timeout: strobe=%0d error=%0d", strobe_cyc[b], err_cyc);
        end
        uart_alive = 1'b1;

        // reset while waiting in DONE
        b = bytes_q.size();
        sum_in = 5'd18;
        pulse_send(5, 0);
        n = 0;
        while (bytes_q.size() < b + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #2;
        check("pre-reset seq_busy", 32'(seq_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid-reset uart_tx_en",   32'(uart_tx_en),   32'd0);
        check("mid-reset uart_tx_data", 32'(uart_tx_data), 32'd0);
        check("mid-reset seq_busy",     32'(seq_busy),     32'd0);
        check("mid-reset frame_done",   32'(frame_done),   32'd0);
        check("mid-reset tx_error",     32'(tx_error),     32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        b = bytes_q.size();
        repeat (100) @(negedge clk);
        check("post-reset no strobe", 32'(bytes_q.size() - b), 32'd0);
        $display("reset-in-DONE: strobes after release=%0d", bytes_q.size() - b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
